// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding for the 5-stage RV32IM core.
// Drives the EX-stage ALU operands and opcode, the forwarded store data and the load-use flag.
module id_ex_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_id_valid,
    input  logic [XLEN-1:0]  i_id_pc,
    input  logic [XLEN-1:0]  i_id_rs1_data,
    input  logic [XLEN-1:0]  i_id_rs2_data,
    input  logic [XLEN-1:0]  i_id_imm,
    input  logic [RADDR-1:0] i_id_rs1_addr,
    input  logic [RADDR-1:0] i_id_rs2_addr,
    input  logic [RADDR-1:0] i_id_rd_addr,
    input  logic             i_id_rd_wren,
    input  logic [3:0]       i_id_alu_op,
    input  logic             i_id_br_un,
    input  logic             i_id_opa_sel,
    input  logic             i_id_opb_sel,
    input  logic [RADDR-1:0] i_mem_rd_addr,
    input  logic             i_mem_rd_wren,
    input  logic             i_mem_is_load,
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic [RADDR-1:0] i_wb_rd_addr,
    input  logic             i_wb_rd_wren,
    input  logic [XLEN-1:0]  i_wb_data,
    output logic [XLEN-1:0]  o_op_a,
    output logic [XLEN-1:0]  o_op_b,
    output logic [3:0]       o_alu_op,
    output logic             o_br_un,
    output logic [XLEN-1:0]  o_store_data,
    output logic [XLEN-1:0]  o_pc,
    output logic [RADDR-1:0] o_rd_addr,
    output logic             o_rd_wren,
    output logic             o_valid,
    output logic             o_load_use
);

    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RADDR-1:0] rs1_addr;
    logic [RADDR-1:0] rs2_addr;
    logic [RADDR-1:0] rd_addr;
    logic             rd_wren;
    logic [3:0]       alu_op;
    logic             br_un;
    logic             opa_sel;
    logic             opb_sel;

    logic             wb_hit_rs1_raw;
    logic             wb_hit_rs2_raw;
    logic             mem_hit_rs1;
    logic             mem_hit_rs2;
    logic             wb_hit_rs1;
    logic             wb_hit_rs2;
    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;

    // WB address matches against the stored sources, used for both the stall refresh and forwarding
    always_comb begin
        wb_hit_rs1_raw = i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == rs1_addr);
        wb_hit_rs2_raw = i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == rs2_addr);
    end

    // EX register: reset > flush > stall (hold, with WB refresh of operand data) > load
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_flush) begin
            valid    <= 1'b0;
            pc       <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            imm      <= '0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            rd_addr  <= '0;
            rd_wren  <= 1'b0;
            alu_op   <= '0;
            br_un    <= 1'b0;
            opa_sel  <= 1'b0;
            opb_sel  <= 1'b0;
        end else if (i_stall) begin
            // WB retires during the stall and will be gone from the pipe afterwards, so absorb it now
            if (wb_hit_rs1_raw) rs1_data <= i_wb_data;
            if (wb_hit_rs2_raw) rs2_data <= i_wb_data;
        end else begin
            valid    <= i_id_valid;
            pc       <= i_id_pc;
            rs1_data <= i_id_rs1_data;
            rs2_data <= i_id_rs2_data;
            imm      <= i_id_imm;
            rs1_addr <= i_id_rs1_addr;
            rs2_addr <= i_id_rs2_addr;
            rd_addr  <= i_id_rd_addr;
            rd_wren  <= i_id_rd_wren & i_id_valid;
            alu_op   <= i_id_alu_op;
            br_un    <= i_id_br_un;
            opa_sel  <= i_id_opa_sel;
            opb_sel  <= i_id_opb_sel;
        end
    end

    // Forwarding network: MEM beats WB, x0 never forwarded, bubbles never match
    always_comb begin
        mem_hit_rs1 = valid && i_mem_rd_wren && (i_mem_rd_addr != '0) && (i_mem_rd_addr == rs1_addr);
        mem_hit_rs2 = valid && i_mem_rd_wren && (i_mem_rd_addr != '0) && (i_mem_rd_addr == rs2_addr);
        wb_hit_rs1  = valid && wb_hit_rs1_raw;
        wb_hit_rs2  = valid && wb_hit_rs2_raw;
        fwd_rs1     = mem_hit_rs1 ? i_mem_data : (wb_hit_rs1 ? i_wb_data : rs1_data);
        fwd_rs2     = mem_hit_rs2 ? i_mem_data : (wb_hit_rs2 ? i_wb_data : rs2_data);
    end

    // Operand selection and hazard flag
    always_comb begin
        o_op_a       = opa_sel ? pc : fwd_rs1;
        o_op_b       = opb_sel ? imm : fwd_rs2;
        o_store_data = fwd_rs2;
        o_load_use   = valid && i_mem_is_load && ((mem_hit_rs1 && !opa_sel) || mem_hit_rs2);
        o_alu_op     = alu_op;
        o_br_un      = br_un;
        o_pc         = pc;
        o_rd_addr    = rd_addr;
        o_rd_wren    = rd_wren;
        o_valid      = valid;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: register capture, forwarding priority, x0 guard,
// stall refresh, flush priority and load-use detection.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rd_wren;
    logic [3:0]  id_alu_op;
    logic        id_br_un, id_opa_sel, id_opb_sel;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_wren, mem_is_load;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_wren;
    logic [31:0] wb_data;
    logic [31:0] op_a, op_b, store_data, pc;
    logic [3:0]  alu_op;
    logic        br_un;
    logic [4:0]  rd_addr;
    logic        rd_wren, valid, load_use;

    int vectors = 0;
    int miscompares = 0;

    id_ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data),
        .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm), .i_id_rs1_addr(id_rs1_addr),
        .i_id_rs2_addr(id_rs2_addr), .i_id_rd_addr(id_rd_addr), .i_id_rd_wren(id_rd_wren),
        .i_id_alu_op(id_alu_op), .i_id_br_un(id_br_un), .i_id_opa_sel(id_opa_sel),
        .i_id_opb_sel(id_opb_sel), .i_mem_rd_addr(mem_rd_addr), .i_mem_rd_wren(mem_rd_wren),
        .i_mem_is_load(mem_is_load), .i_mem_data(mem_data), .i_wb_rd_addr(wb_rd_addr),
        .i_wb_rd_wren(wb_rd_wren), .i_wb_data(wb_data),
        .o_op_a(op_a), .o_op_b(op_b), .o_alu_op(alu_op), .o_br_un(br_un),
        .o_store_data(store_data), .o_pc(pc), .o_rd_addr(rd_addr), .o_rd_wren(rd_wren),
        .o_valid(valid), .o_load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic drive_id(input logic v, input logic [31:0] p, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] im, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [4:0] rd, input logic wr,
                            input logic [3:0] op, input logic bu, input logic sa, input logic sb);
        id_valid = v; id_pc = p; id_rs1_data = d1; id_rs2_data = d2; id_imm = im;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd; id_rd_wren = wr;
        id_alu_op = op; id_br_un = bu; id_opa_sel = sa; id_opb_sel = sb;
    endtask

    task automatic fwd_idle();
        mem_rd_addr = '0; mem_rd_wren = 1'b0; mem_is_load = 1'b0; mem_data = '0;
        wb_rd_addr = '0; wb_rd_wren = 1'b0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        fwd_idle();
        drive_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b exp 0", valid); end
        vectors++; if (alu_op !== 4'd0) begin miscompares++; $display("FAIL rst_alu_op got %0d exp 0", alu_op); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", pc); end
        vectors++; if (op_a !== 32'h0) begin miscompares++; $display("FAIL rst_op_a got %h exp 0", op_a); end
        vectors++; if (op_b !== 32'h0) begin miscompares++; $display("FAIL rst_op_b got %h exp 0", op_b); end
        vectors++; if (store_data !== 32'h0) begin miscompares++; $display("FAIL rst_store got %h exp 0", store_data); end
        vectors++; if (rd_wren !== 1'b0) begin miscompares++; $display("FAIL rst_rd_wren got %0b exp 0", rd_wren); end
        rst = 1'b0;
        tick();
        // Load a live instruction, then hit reset between edges
        drive_id(1'b1, 32'h40, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd9, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid got %0b exp 1", valid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL async_rst_valid got %0b exp 0", valid); end
        vectors++; if (alu_op !== 4'd0) begin miscompares++; $display("FAIL async_rst_alu_op got %0d exp 0", alu_op); end
        #1 rst = 1'b0;
    endtask

    task automatic test_load();
        fwd_idle();
        drive_id(1'b1, 32'h100, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd4, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (op_a !== 32'h11) begin miscompares++; $display("FAIL ld_op_a got %h exp 11", op_a); end
        vectors++; if (op_b !== 32'h22) begin miscompares++; $display("FAIL ld_op_b got %h exp 22", op_b); end
        vectors++; if (store_data !== 32'h22) begin miscompares++; $display("FAIL ld_store got %h exp 22", store_data); end
        vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL ld_pc got %h exp 100", pc); end
        vectors++; if (alu_op !== 4'd10) begin miscompares++; $display("FAIL ld_alu_op got %0d exp 10", alu_op); end
        vectors++; if (br_un !== 1'b1) begin miscompares++; $display("FAIL ld_br_un got %0b exp 1", br_un); end
        vectors++; if (rd_addr !== 5'd4) begin miscompares++; $display("FAIL ld_rd_addr got %0d exp 4", rd_addr); end
        vectors++; if (rd_wren !== 1'b1) begin miscompares++; $display("FAIL ld_rd_wren got %0b exp 1", rd_wren); end
        drive_id(1'b1, 32'h104, 32'h11, 32'h22, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        vectors++; if (op_a !== 32'h104) begin miscompares++; $display("FAIL sel_op_a got %h exp 104", op_a); end
        vectors++; if (op_b !== 32'hFFFF_FFF0) begin miscompares++; $display("FAIL sel_op_b got %h exp fffffff0", op_b); end
        vectors++; if (store_data !== 32'h22) begin miscompares++; $display("FAIL sel_store got %h exp 22", store_data); end
        drive_id(1'b0, 32'h108, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL inv_valid got %0b exp 0", valid); end
        vectors++; if (rd_wren !== 1'b0) begin miscompares++; $display("FAIL inv_rd_wren got %0b exp 0", rd_wren); end
    endtask

    task automatic test_mem_fwd();
        fwd_idle();
        drive_id(1'b1, 32'h200, 32'h5555, 32'h6666, 32'h0, 5'd5, 5'd6, 5'd8, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        mem_rd_addr = 5'd5; mem_rd_wren = 1'b1; mem_data = 32'h1234;
        wb_rd_addr = 5'd5; wb_rd_wren = 1'b1; wb_data = 32'hBEEF;
        #1;
        vectors++; if (op_a !== 32'h1234) begin miscompares++; $display("FAIL mem_beats_wb got %h exp 1234", op_a); end
        mem_rd_wren = 1'b0;
        #1;
        vectors++; if (op_a !== 32'hBEEF) begin miscompares++; $display("FAIL wb_fwd got %h exp beef", op_a); end
        wb_rd_addr = 5'd6;
        #1;
        vectors++; if (op_a !== 32'h5555) begin miscompares++; $display("FAIL no_fwd_a got %h exp 5555", op_a); end
        vectors++; if (store_data !== 32'hBEEF) begin miscompares++; $display("FAIL wb_fwd_rs2 got %h exp beef", store_data); end
        vectors++; if (op_b !== 32'hBEEF) begin miscompares++; $display("FAIL wb_fwd_opb got %h exp beef", op_b); end
        fwd_idle();
    endtask

    task automatic test_x0_guard();
        fwd_idle();
        drive_id(1'b1, 32'h300, 32'h7, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        mem_rd_addr = 5'd0; mem_rd_wren = 1'b1; mem_data = 32'hFFFF_FFFF;
        wb_rd_addr = 5'd0; wb_rd_wren = 1'b1; wb_data = 32'hDEAD_BEEF;
        #1;
        vectors++; if (op_b !== 32'h0) begin miscompares++; $display("FAIL x0_op_b got %h exp 0", op_b); end
        vectors++; if (store_data !== 32'h0) begin miscompares++; $display("FAIL x0_store got %h exp 0", store_data); end
        fwd_idle();
    endtask

    task automatic test_stall_refresh();
        fwd_idle();
        drive_id(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd7, 5'd8, 5'd9, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        drive_id(1'b1, 32'h500, 32'h999, 32'h888, 32'h0, 5'd3, 5'd4, 5'd5, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        wb_rd_addr = 5'd7; wb_rd_wren = 1'b1; wb_data = 32'hA5A5_0000;
        tick();
        fwd_idle();
        vectors++; if (pc !== 32'h400) begin miscompares++; $display("FAIL stall_hold_pc got %h exp 400", pc); end
        vectors++; if (alu_op !== 4'd2) begin miscompares++; $display("FAIL stall_hold_op got %0d exp 2", alu_op); end
        tick();
        stall = 1'b0;
        #1;
        vectors++; if (op_a !== 32'hA5A5_0000) begin miscompares++; $display("FAIL stall_refresh got %h exp a5a50000", op_a); end
        vectors++; if (op_b !== 32'h0) begin miscompares++; $display("FAIL stall_rs2_kept got %h exp 0", op_b); end
        tick();
        vectors++; if (pc !== 32'h500) begin miscompares++; $display("FAIL post_stall_pc got %h exp 500", pc); end
    endtask

    task automatic test_flush();
        fwd_idle();
        drive_id(1'b1, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0b exp 0", valid); end
        vectors++; if (rd_wren !== 1'b0) begin miscompares++; $display("FAIL flush_rd_wren got %0b exp 0", rd_wren); end
        vectors++; if (alu_op !== 4'd0) begin miscompares++; $display("FAIL flush_alu_op got %0d exp 0", alu_op); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL flush_pc got %h exp 0", pc); end
    endtask

    task automatic test_load_use();
        fwd_idle();
        drive_id(1'b1, 32'h700, 32'h0, 32'h0, 32'h10, 5'd9, 5'd3, 5'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        mem_rd_addr = 5'd3; mem_rd_wren = 1'b1; mem_is_load = 1'b1; mem_data = 32'h77;
        #1;
        vectors++; if (load_use !== 1'b1) begin miscompares++; $display("FAIL lu_rs2 got %0b exp 1", load_use); end
        mem_is_load = 1'b0;
        #1;
        vectors++; if (load_use !== 1'b0) begin miscompares++; $display("FAIL lu_not_load got %0b exp 0", load_use); end
        mem_is_load = 1'b1; mem_rd_addr = 5'd9;
        #1;
        vectors++; if (load_use !== 1'b1) begin miscompares++; $display("FAIL lu_rs1 got %0b exp 1", load_use); end
        fwd_idle();
        drive_id(1'b1, 32'h704, 32'h0, 32'h0, 32'h0, 5'd9, 5'd4, 5'd4, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        mem_rd_addr = 5'd9; mem_rd_wren = 1'b1; mem_is_load = 1'b1;
        #1;
        vectors++; if (load_use !== 1'b0) begin miscompares++; $display("FAIL lu_rs1_pc_sel got %0b exp 0", load_use); end
        fwd_idle();
    endtask

    initial begin
        test_reset();
        test_load();
        test_mem_fwd();
        test_x0_guard();
        test_stall_refresh();
        test_flush();
        test_load_use();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
